// File: rtl/syndrome_error_corrector.sv
// syndrome_error_corrector: buffers codewords, applies single-bit syndrome correction, streams result
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   codeword_in_*           - raw codeword stream (data, tlast, valid/ready), buffered in a FIFO
//   syndrome_in_*           - one syndrome per buffered codeword, same order
//   data_out_*              - corrected words with the codeword's tlast (registered, valid/ready)
//   uncorrectable           - one-cycle pulse on the first valid cycle of a word with an illegal syndrome
//   corrected_count         - saturating count of corrected words
//   uncorrectable_count     - saturating count of uncorrectable words
//
// Build option: define ERROR_COUNTERS_EN to implement the statistics counters;
// otherwise both count outputs are tied to zero.
module syndrome_error_corrector #(
    parameter int DATA_WIDTH = 32,
    parameter int SYN_WIDTH  = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] codeword_in_data,
    input  logic                  codeword_in_tlast,
    input  logic                  codeword_in_valid,
    output logic                  codeword_in_ready,
    input  logic [SYN_WIDTH-1:0]  syndrome_in_data,
    input  logic                  syndrome_in_valid,
    output logic                  syndrome_in_ready,
    output logic [DATA_WIDTH-1:0] data_out_data,
    output logic                  data_out_tlast,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  uncorrectable,
    output logic [CNT_WIDTH-1:0]  corrected_count,
    output logic [CNT_WIDTH-1:0]  uncorrectable_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  full, empty, push, pop, illegal;
    logic [DATA_WIDTH:0]   head;
    logic [DATA_WIDTH-1:0] mask;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;

    // Reset is folded in so the input is not offered while reset is held.
    assign codeword_in_ready = reset && !full;
    assign syndrome_in_ready = !empty && (!data_out_valid || data_out_ready);
    assign push = codeword_in_valid && codeword_in_ready;
    assign pop  = syndrome_in_valid && syndrome_in_ready;
    assign head = mem[rd_ptr[AW-1:0]];

    // Syndrome s in 1..DATA_WIDTH selects bit s-1; anything larger cannot be fixed.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            mask[i] = 32'(syndrome_in_data) == i + 1;
        illegal = 32'(syndrome_in_data) > DATA_WIDTH;
    end

    always_ff @(posedge clock)
        if (push)
            mem[wr_ptr[AW-1:0]] <= {codeword_in_tlast, codeword_in_data};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A syndrome is only accepted when the output slot is free, so every load
    // starts a fresh beat and the uncorrectable pulse marks its first cycle only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out_data  <= '0;
            data_out_tlast <= 1'b0;
            data_out_valid <= 1'b0;
            uncorrectable  <= 1'b0;
        end else if (pop) begin
            data_out_data  <= head[DATA_WIDTH-1:0] ^ mask;
            data_out_tlast <= head[DATA_WIDTH];
            data_out_valid <= 1'b1;
            uncorrectable  <= illegal;
        end else begin
            uncorrectable  <= 1'b0;
            if (data_out_ready)
                data_out_valid <= 1'b0;
        end
    end

`ifdef ERROR_COUNTERS_EN
    logic [CNT_WIDTH-1:0] corr_cnt, unc_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            corr_cnt <= '0;
            unc_cnt  <= '0;
        end else begin
            if (pop && |mask && !(&corr_cnt))
                corr_cnt <= corr_cnt + 1'b1;
            if (pop && illegal && !(&unc_cnt))
                unc_cnt <= unc_cnt + 1'b1;
        end
    end

    assign corrected_count     = corr_cnt;
    assign uncorrectable_count = unc_cnt;
`else
    assign corrected_count     = '0;
    assign uncorrectable_count = '0;
`endif
endmodule

// File: tb/tb_syndrome_error_corrector.sv
// tb_syndrome_error_corrector: directed self-checking bench for syndrome_error_corrector
module tb_syndrome_error_corrector;
`ifdef ERROR_COUNTERS_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] codeword_in_data;
    logic        codeword_in_tlast, codeword_in_valid, codeword_in_ready;
    logic [5:0]  syndrome_in_data;
    logic        syndrome_in_valid, syndrome_in_ready;
    logic [31:0] data_out_data;
    logic        data_out_tlast, data_out_valid, data_out_ready;
    logic        uncorrectable;
    logic [3:0]  corrected_count, uncorrectable_count;

    int total = 0;
    int bad   = 0;

    syndrome_error_corrector #(.DATA_WIDTH(32), .SYN_WIDTH(6), .FIFO_DEPTH(8), .CNT_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .codeword_in_data(codeword_in_data), .codeword_in_tlast(codeword_in_tlast),
        .codeword_in_valid(codeword_in_valid), .codeword_in_ready(codeword_in_ready),
        .syndrome_in_data(syndrome_in_data), .syndrome_in_valid(syndrome_in_valid),
        .syndrome_in_ready(syndrome_in_ready),
        .data_out_data(data_out_data), .data_out_tlast(data_out_tlast),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .uncorrectable(uncorrectable),
        .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        codeword_in_data  = d;
        codeword_in_tlast = l;
        codeword_in_valid = 1'b1;
        for (int k = 0; k < 20 && !codeword_in_ready; k++) begin
            @(posedge clock); #1;
        end
        chk("push_ready", codeword_in_ready, 1);
        @(posedge clock); #1;
        codeword_in_valid = 1'b0;
    endtask

    task automatic syn(input logic [5:0] s);
        syndrome_in_data  = s;
        syndrome_in_valid = 1'b1;
        for (int k = 0; k < 20 && !syndrome_in_ready; k++) begin
            @(posedge clock); #1;
        end
        chk("syn_ready", syndrome_in_ready, 1);
        @(posedge clock); #1;
        syndrome_in_valid = 1'b0;
    endtask

    initial begin
        int sent, got;
        logic prev_stall;
        logic [31:0] prev_data;
        reset = 1'b0;
        codeword_in_data = '0; codeword_in_tlast = 1'b0; codeword_in_valid = 1'b0;
        syndrome_in_data = '0; syndrome_in_valid = 1'b0; data_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cw_ready", codeword_in_ready, 0);
        chk("rst_syn_ready", syndrome_in_ready, 0);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_data", data_out_data, 0);
        chk("rst_tlast", data_out_tlast, 0);
        chk("rst_unc", uncorrectable, 0);
        chk("rst_corr_cnt", corrected_count, 0);
        chk("rst_unc_cnt", uncorrectable_count, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_cw_ready", codeword_in_ready, 1);

        // clean path
        push(32'h0000_00A5, 1'b0);
        push(32'hDEAD_BEEF, 1'b1);
        syn(6'd0);
        chk("clean0_valid", data_out_valid, 1);
        chk("clean0_data", data_out_data, 32'h0000_00A5);
        chk("clean0_tlast", data_out_tlast, 0);
        chk("clean0_unc", uncorrectable, 0);
        syn(6'd0);
        chk("clean1_valid", data_out_valid, 1);
        chk("clean1_data", data_out_data, 32'hDEAD_BEEF);
        chk("clean1_tlast", data_out_tlast, 1);
        @(posedge clock); #1;
        chk("clean_drained", data_out_valid, 0);
        chk("clean_corr_cnt", corrected_count, 0);

        // single-bit fixes at both ends of the word
        push(32'h0000_0001, 1'b0);
        push(32'h1234_5678, 1'b0);
        syn(6'd1);
        chk("fix_s1", data_out_data, 32'h0000_0000);
        syn(6'd32);
        chk("fix_s32", data_out_data, 32'h9234_5678);
        chk("fix_corr_cnt", corrected_count, CE ? 2 : 0);
        @(posedge clock); #1;

        // uncorrectable
        push(32'hCAFE_F00D, 1'b0);
        syn(6'd40);
        chk("unc_valid", data_out_valid, 1);
        chk("unc_data", data_out_data, 32'hCAFE_F00D);
        chk("unc_pulse", uncorrectable, 1);
        chk("unc_cnt", uncorrectable_count, CE ? 1 : 0);
        chk("unc_corr_cnt", corrected_count, CE ? 2 : 0);
        @(posedge clock); #1;
        chk("unc_pulse_end", uncorrectable, 0);

        // fill the FIFO, then drain under toggling backpressure
        data_out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push(32'h100 + i, i == 7);
        chk("full_cw_ready", codeword_in_ready, 0);
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
        syndrome_in_data = 6'd0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            data_out_ready    = c[0];
            syndrome_in_valid = sent < 8;
            #1;
            if (syndrome_in_valid && syndrome_in_ready)
                sent++;
            if (prev_stall)
                chk("bp_stall_hold", data_out_data, prev_data);
            if (data_out_valid) begin
                chk("bp_data", data_out_data, 32'h100 + got);
                if (data_out_ready) begin
                    if (got == 7)
                        chk("bp_tlast", data_out_tlast, 1);
                    got++;
                end
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_data  = data_out_data;
            @(posedge clock); #1;
        end
        syndrome_in_valid = 1'b0;
        data_out_ready = 1'b1;
        chk("bp_count", got, 8);
        chk("bp_empty", syndrome_in_ready, 0);
        chk("bp_cw_ready", codeword_in_ready, 1);

        // reset mid-stream with 3 words buffered and an output pending
        data_out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'hA0 + i, 1'b0);
        syn(6'd3);
        chk("mid_valid", data_out_valid, 1);
        chk("mid_data", data_out_data, 32'hA4);
        chk("mid_corr_cnt", corrected_count, CE ? 3 : 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("mid_rst_valid", data_out_valid, 0);
        chk("mid_rst_data", data_out_data, 0);
        chk("mid_rst_corr_cnt", corrected_count, 0);
        chk("mid_rst_unc_cnt", uncorrectable_count, 0);
        reset = 1'b1;
        data_out_ready = 1'b1;
        #1;
        chk("mid_fifo_empty", syndrome_in_ready, 0);
        push(32'h55, 1'b1);
        syn(6'd2);
        chk("mid_next_data", data_out_data, 32'h57);
        chk("mid_next_tlast", data_out_tlast, 1);
        chk("mid_next_corr_cnt", corrected_count, CE ? 1 : 0);

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            push(i, 1'b0);
            syn(6'd5);
            chk("sat_data", data_out_data, i ^ 32'h10);
            if (i == 13)
                chk("sat_at_15", corrected_count, CE ? 15 : 0);
        end
        chk("sat_corr_cnt", corrected_count, CE ? 15 : 0);
        chk("sat_unc_cnt", uncorrectable_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
